// File: rtl/ddr_wr_serialiser.sv
// Write-side DDR data path: sequences write latency, DQS preamble, data burst and postamble.
// Byte-mask path (wr_mask -> dm_r/dm_f) is built only when DDR_WR_MASK_EN is defined.
module ddr_wr_serialiser #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned BURST_CYCLES = 2,
  parameter int unsigned WLAT         = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   cmd_write,
  output logic                   cmd_ready,
  output logic                   wr_data_req,
  input  logic [2*WIDTH-1:0]     wr_data,
`ifdef DDR_WR_MASK_EN
  input  logic [2*WIDTH/8-1:0]   wr_mask,
  output logic [WIDTH/8-1:0]     dm_r,
  output logic [WIDTH/8-1:0]     dm_f,
`endif
  output logic [WIDTH-1:0]       dq_r,
  output logic [WIDTH-1:0]       dq_f,
  output logic                   dq_oe,
  output logic                   dqs_r,
  output logic                   dqs_f,
  output logic                   dqs_oe,
  output logic                   busy
);

  localparam int unsigned DW    = 2 * WIDTH;
  localparam int unsigned CNT_W = 3;
`ifdef DDR_WR_MASK_EN
  localparam int unsigned MW    = WIDTH / 8;
`endif
  localparam logic [CNT_W-1:0] WAIT_INIT  = CNT_W'(WLAT - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_CYCLES - 1);
  localparam logic             MULTI_BEAT = 1'(BURST_CYCLES > 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_BURST,
    S_POST
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_beat;
  logic             r_cmd_ready;
  logic             r_busy;
  logic             r_req;
  logic             r_dq_oe;
  logic             r_dqs_oe;
  logic             r_dqs_r;
  logic             r_dqs_f;
  logic [WIDTH-1:0] r_dq_r;
  logic [WIDTH-1:0] r_dq_f;
`ifdef DDR_WR_MASK_EN
  logic [MW-1:0]    r_dm_r;
  logic [MW-1:0]    r_dm_f;
`endif

  // Outputs are decoded from the state being entered, so each is valid for that state's whole cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_beat      <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_req       <= 1'b0;
      r_dq_oe     <= 1'b0;
      r_dqs_oe    <= 1'b0;
      r_dqs_r     <= 1'b0;
      r_dqs_f     <= 1'b0;
      r_dq_r      <= '0;
      r_dq_f      <= '0;
`ifdef DDR_WR_MASK_EN
      r_dm_r      <= '0;
      r_dm_f      <= '0;
`endif
    end else if (clk_en) begin
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b1;
      r_req       <= 1'b0;
      r_dq_oe     <= 1'b0;
      r_dqs_oe    <= 1'b0;
      r_dqs_r     <= 1'b0;
      r_dqs_f     <= 1'b0;

      // A pop always leads into a BURST beat; DQ keeps its last value otherwise.
      if (r_req) begin
        r_dq_r <= wr_data[WIDTH-1:0];
        r_dq_f <= wr_data[DW-1:WIDTH];
      end
`ifdef DDR_WR_MASK_EN
      r_dm_r <= r_req ? wr_mask[MW-1:0]    : '0;
      r_dm_f <= r_req ? wr_mask[2*MW-1:MW] : '0;
`endif

      unique case (r_state)
        S_IDLE, S_POST: begin
          if (cmd_write) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= WAIT_INIT;
          end else begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state  <= S_PRE;
            r_dqs_oe <= 1'b1;
            r_req    <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end
        end
        S_PRE: begin
          r_state  <= S_BURST;
          r_beat   <= '0;
          r_dqs_oe <= 1'b1;
          r_dqs_r  <= 1'b1;
          r_dq_oe  <= 1'b1;
          r_req    <= MULTI_BEAT;
        end
        S_BURST: begin
          if (r_beat == BEAT_LAST) begin
            r_state     <= S_POST;
            r_dqs_oe    <= 1'b1;
            r_cmd_ready <= 1'b1;
          end else begin
            r_beat   <= r_beat + CNT_W'(1);
            r_dqs_oe <= 1'b1;
            r_dqs_r  <= 1'b1;
            r_dq_oe  <= 1'b1;
            r_req    <= ((r_beat + CNT_W'(1)) != BEAT_LAST);
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign wr_data_req = r_req;
  assign dq_oe       = r_dq_oe;
  assign dqs_oe      = r_dqs_oe;
  assign dqs_r       = r_dqs_r;
  assign dqs_f       = r_dqs_f;
  assign dq_r        = r_dq_r;
  assign dq_f        = r_dq_f;
`ifdef DDR_WR_MASK_EN
  assign dm_r        = r_dm_r;
  assign dm_f        = r_dm_f;
`endif

endmodule

// File: tb/tb_ddr_wr_serialiser.sv
// Scoreboard bench for ddr_wr_serialiser: a burst-phase timeline model predicts control outputs
// and queues the words expected on DQ; a negedge monitor compares. Honours DDR_WR_MASK_EN.
module tb_ddr_wr_serialiser;

  localparam int WIDTH = 16;
  localparam int BC    = 2;
  localparam int WLAT  = 1;
  localparam int DW    = 2 * WIDTH;
  localparam int MW    = WIDTH / 8;
  localparam int L     = WLAT + BC + 2;   // phases 1..L of one burst, L = POSTAMBLE

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clk_en = 1'b0;
  logic cmd_write = 1'b0;
  logic [DW-1:0]   wr_data = '0;
  logic [2*MW-1:0] wr_mask = '0;
  logic cmd_ready, wr_data_req, dq_oe, dqs_r, dqs_f, dqs_oe, busy;
  logic [WIDTH-1:0] dq_r, dq_f;
`ifdef DDR_WR_MASK_EN
  logic [MW-1:0] dm_r, dm_f;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [DW-1:0]   d;
    logic [2*MW-1:0] m;
  } beat_t;

  beat_t exp_q[$];
  beat_t dir_q[$];
  int    m_k = 0;          // 0 = idle, else cycles since command acceptance
  bit    new_beat = 1'b0;

  always #5 clock = ~clock;

  ddr_wr_serialiser #(.WIDTH(WIDTH), .BURST_CYCLES(BC), .WLAT(WLAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .clk_en      (clk_en),
    .cmd_write   (cmd_write),
    .cmd_ready   (cmd_ready),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
`ifdef DDR_WR_MASK_EN
    .wr_mask     (wr_mask),
    .dm_r        (dm_r),
    .dm_f        (dm_f),
`endif
    .dq_r        (dq_r),
    .dq_f        (dq_f),
    .dq_oe       (dq_oe),
    .dqs_r       (dqs_r),
    .dqs_f       (dqs_f),
    .dqs_oe      (dqs_oe),
    .busy        (busy)
  );

  function automatic bit in_burst(input int k);
    return (k >= WLAT + 2) && (k <= WLAT + 1 + BC);
  endfunction

  // Pops happen in PREAMBLE and every burst beat but the last.
  function automatic bit req_at(input int k);
    return (k == WLAT + 1) || ((k >= WLAT + 2) && (k <= WLAT + BC));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference timeline: advances one phase per enabled edge.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_k = 0;
      exp_q.delete();
      new_beat = 1'b0;
    end else begin
      new_beat = 1'b0;
      if (clk_en) begin
        if (req_at(m_k)) exp_q.push_back('{wr_data, wr_mask});
        if (cmd_write && (m_k == 0 || m_k == L)) m_k = 1;
        else if (m_k == L)                       m_k = 0;
        else if (m_k > 0)                        m_k = m_k + 1;
        new_beat = in_burst(m_k);
      end
    end
  end

  // Monitor: control every cycle, data once per burst beat.
  always @(negedge clock) begin
    if (!reset) begin
      beat_t b;
      chk("cmd_ready",   64'(cmd_ready),   64'(m_k == 0 || m_k == L));
      chk("busy",        64'(busy),        64'(m_k != 0));
      chk("wr_data_req", 64'(wr_data_req), 64'(req_at(m_k)));
      chk("dqs_oe",      64'(dqs_oe),      64'(m_k >= WLAT + 1));
      chk("dqs_r",       64'(dqs_r),       64'(in_burst(m_k)));
      chk("dqs_f",       64'(dqs_f),       64'(0));
      chk("dq_oe",       64'(dq_oe),       64'(in_burst(m_k)));
      if (new_beat) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 64'(exp_q.size()), 64'(1));
        end else begin
          b = exp_q.pop_front();
          chk("dq_r", 64'(dq_r), 64'(b.d[WIDTH-1:0]));
          chk("dq_f", 64'(dq_f), 64'(b.d[DW-1:WIDTH]));
`ifdef DDR_WR_MASK_EN
          chk("dm_r", 64'(dm_r), 64'(b.m[MW-1:0]));
          chk("dm_f", 64'(dm_f), 64'(b.m[2*MW-1:MW]));
`endif
        end
      end
`ifdef DDR_WR_MASK_EN
      if (!in_burst(m_k)) begin
        chk("dm_r_idle", 64'(dm_r), 64'(0));
        chk("dm_f_idle", 64'(dm_f), 64'(0));
      end
`endif
    end
  end

  // Drive inputs for the cycle that has just started (called right after a negedge).
  task automatic drive(input logic cmd, input logic en);
    beat_t b;
    cmd_write = cmd;
    clk_en    = en;
    if (en && req_at(m_k) && dir_q.size() > 0) begin
      b       = dir_q.pop_front();
      wr_data = b.d;
      wr_mask = b.m;
    end else begin
      wr_data = DW'({$urandom(), $urandom()});
      wr_mask = (2*MW)'($urandom());
    end
  endtask

  task automatic cyc(input logic cmd, input logic en);
    @(negedge clock);
    drive(cmd, en);
  endtask

  // Run enabled idle-command cycles until the model reaches phase k, then drive (cmd, en).
  task automatic run_until(input int k, input logic cmd, input logic en);
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (m_k == k) begin
        drive(cmd, en);
        return;
      end
      drive(1'b0, 1'b1);
    end
    n_tests++;
    n_fail++;
    $display("FAIL phase_timeout: waiting for phase %0d, model at %0d", k, m_k);
  endtask

  // Assert reset between edges and check outputs clear before the next edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready),   64'(1));
    chk("rst_busy",      64'(busy),        64'(0));
    chk("rst_req",       64'(wr_data_req), 64'(0));
    chk("rst_dq_oe",     64'(dq_oe),       64'(0));
    chk("rst_dqs_oe",    64'(dqs_oe),      64'(0));
    chk("rst_dqs_r",     64'(dqs_r),       64'(0));
    chk("rst_dq_r",      64'(dq_r),        64'(0));
    chk("rst_dq_f",      64'(dq_f),        64'(0));
    @(negedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    beat_t b;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    repeat (2) cyc(1'b0, 1'b1);

    // Single burst with known data and mask.
    b.d = 32'hBEEF_1234; b.m = 4'b1001; dir_q.push_back(b);
    b.d = 32'hCAFE_5678; b.m = 4'b0000; dir_q.push_back(b);
    cyc(1'b1, 1'b1);
    repeat (7) cyc(1'b0, 1'b1);

    // Back-to-back bursts: second command lands in POSTAMBLE.
    cyc(1'b1, 1'b1);
    run_until(L, 1'b1, 1'b1);
    run_until(L, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b1);

    // Clock-enable stall during burst beat 0.
    cyc(1'b1, 1'b1);
    run_until(WLAT + 2, 1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    run_until(0, 1'b0, 1'b1);

    // Async reset mid-burst, then commands while busy.
    cyc(1'b1, 1'b1);
    run_until(WLAT + 2, 1'b0, 1'b1);
    async_reset();
    repeat (6) cyc(1'b1, 1'b1);
    run_until(0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        cyc(1'b0, 1'b1);
        async_reset();
      end else begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0));
      end
    end

    run_until(0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
